// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU slice: the default datapath width,
// the opcode class and function codes, branch flag encodings and the FSM state
// type used by seq_alu.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Default datapath / accumulator width in bits.
  localparam int DEFAULT_W = 8;

  // Opcode classes carried on the Op input.
  localparam logic OP_REG = 1'b0;
  localparam logic OP_IMM = 1'b1;

  // Register-class (Op = 0) function codes.
  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_MOV  = 4'b0001;
  localparam logic [3:0] F_HALT = 4'b0010;
  localparam logic [3:0] F_SLT  = 4'b0011;
  localparam logic [3:0] F_SET  = 4'b0100;
  localparam logic [3:0] F_SUB  = 4'b0101;
  localparam logic [3:0] F_SLL  = 4'b0110;
  localparam logic [3:0] F_OR   = 4'b1000;
  localparam logic [3:0] F_SLR  = 4'b1001;
  localparam logic [3:0] F_BEZR = 4'b1010;
  localparam logic [3:0] F_MUL  = 4'b1101;

  // Immediate-class (Op = 1) function codes.
  localparam logic [3:0] FI_SETI = 4'b0000;
  localparam logic [3:0] FI_SLIZ = 4'b0001;
  localparam logic [3:0] FI_SLTI = 4'b0010;

  // Branch flag encodings reported on Zero.
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_FWD  = 2'b01;
  localparam logic [1:0] BR_BACK = 2'b10;

  // Control FSM: idle/accepting, or stepping a multi-cycle operation.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Purely combinational datapath for every operation that completes in a single
// cycle. It also covers SLIZ with a zero shift count (result is the unchanged
// accumulator). Multi-cycle work (MUL, SLIZ with k >= 1) is stepped in seq_alu.
//
// Ports
//   op         opcode class (0 = register, 1 = immediate)
//   func       function select within the class
//   accu       accumulator value (operand A)
//   data_in    operand B / immediate
//   result     value to be registered into Out
//   carry      carry / borrow flag for this operation (0 when undefined)
//   zero       branch flag (only BEZR sets a non-zero value)
//   load_accu  1 when the accumulator must take result
//   halt       1 for the HALT operation
// -----------------------------------------------------------------------------
module alu_comb
  import alu_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         op,
  input  logic [3:0]   func,
  input  logic [W-1:0] accu,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] result,
  output logic         carry,
  output logic [1:0]   zero,
  output logic         load_accu,
  output logic         halt
);

  logic [W:0]   add_sum;
  logic [W-1:0] sub_diff;
  logic         ge_flag;

  // Shared arithmetic terms. The adder keeps the extra top bit so ADD can
  // report its carry-out directly.
  always_comb begin
    add_sum  = {1'b0, accu} + {1'b0, data_in};
    sub_diff = accu - data_in;
    ge_flag  = (data_in >= accu);
  end

  // Operation decode. Everything defaults to a NOP: result 0, flags cleared,
  // accumulator untouched.
  always_comb begin
    result    = '0;
    carry     = 1'b0;
    zero      = BR_NONE;
    load_accu = 1'b0;
    halt      = 1'b0;
    if (op == OP_REG) begin
      case (func)
        F_ADD: begin
          result    = add_sum[W-1:0];
          carry     = add_sum[W];
          load_accu = 1'b1;
        end
        F_MOV: begin
          result = accu;
        end
        F_HALT: begin
          halt = 1'b1;
        end
        F_SLT: begin
          result = {{(W-1){1'b0}}, ge_flag};
        end
        F_SET: begin
          result    = data_in;
          load_accu = 1'b1;
        end
        F_SUB: begin
          result    = sub_diff;
          carry     = (data_in > accu);
          load_accu = 1'b1;
        end
        F_SLL: begin
          // Shifted-out MSB goes to Carry; the accumulator is OR-ed in so
          // repeated SLL can assemble a value bit by bit.
          result    = {data_in[W-2:0], 1'b0} | accu;
          carry     = data_in[W-1];
          load_accu = 1'b1;
        end
        F_OR: begin
          result    = accu | data_in;
          load_accu = 1'b1;
        end
        F_SLR: begin
          result    = {1'b0, data_in[W-1:1]};
          load_accu = 1'b1;
        end
        F_BEZR: begin
          // Branch only when the accumulator is zero; a negative offset is
          // reported as a backward branch with its magnitude on result.
          if (accu == '0) begin
            if (data_in[W-1]) begin
              result = '0 - data_in;
              zero   = BR_BACK;
            end else begin
              result = data_in;
              zero   = BR_FWD;
            end
          end
        end
        default: begin
        end
      endcase
    end else begin
      case (func)
        FI_SETI: begin
          result    = data_in;
          load_accu = 1'b1;
        end
        FI_SLIZ: begin
          // Only reached with a zero shift count: the accumulator is the result.
          result    = accu;
          load_accu = 1'b1;
        end
        FI_SLTI: begin
          result = {{(W-1){1'b0}}, ge_flag};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Small sequential ALU with an internal accumulator. Single-cycle operations
// complete on the edge that accepts Start; SLIZ (shift accumulator left k
// times) and MUL (shift-add multiply) step one bit per cycle under a two-state
// FSM. Results and flags are registered and announced by a one-cycle Done.
//
// Ports
//   Clk     sole clock, rising edge
//   Reset   synchronous active-high reset, wins over Start
//   Start   operation request, sampled only while Busy = 0 and Halted = 0
//   Op      opcode class (0 = register, 1 = immediate)
//   Func    function select within the class
//   DataIn  operand B / immediate / shift count
//   Out     registered result of the last completed operation
//   Accu    accumulator (operand A)
//   Carry   registered carry / borrow / multiply-overflow flag
//   Zero    registered branch flag (00 none, 01 forward, 10 backward)
//   Busy    multi-cycle operation in progress
//   Done    one-cycle pulse when Out and the flags are updated
//   Halted  sticky halt indicator, cleared only by Reset
// -----------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int W   = DEFAULT_W,
  parameter int SHW = $clog2(W) + 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Op,
  input  logic [3:0]   Func,
  input  logic [W-1:0] DataIn,
  output logic [W-1:0] Out,
  output logic [W-1:0] Accu,
  output logic         Carry,
  output logic [1:0]   Zero,
  output logic         Busy,
  output logic         Done,
  output logic         Halted
);

  localparam logic [W-1:0] W_LIMIT = W[W-1:0];

  state_t         state;
  logic [SHW-1:0] cnt;
  logic           run_mul;
  logic [2*W-1:0] prod;

  logic           is_mul;
  logic           is_sliz;
  logic [SHW-1:0] sliz_k;
  logic [W-1:0]   accu_shl;

  logic [2*W-1:0] mul_src;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;

  logic [W-1:0]   c_result;
  logic           c_carry;
  logic [1:0]     c_zero;
  logic           c_load;
  logic           c_halt;

  alu_comb #(
    .W (W)
  ) u_alu_comb (
    .op        (Op),
    .func      (Func),
    .accu      (Accu),
    .data_in   (DataIn),
    .result    (c_result),
    .carry     (c_carry),
    .zero      (c_zero),
    .load_accu (c_load),
    .halt      (c_halt)
  );

  assign Busy = (state == ST_RUN);

  // Classify the incoming request and clamp the SLIZ count to W, since any
  // count of W or more clears the accumulator anyway.
  always_comb begin
    is_mul   = (Op == OP_REG) && (Func == F_MUL);
    is_sliz  = (Op == OP_IMM) && (Func == FI_SLIZ);
    sliz_k   = (DataIn >= W_LIMIT) ? SHW'(W) : SHW'(DataIn);
    accu_shl = {Accu[W-2:0], 1'b0};
  end

  // One shift-add multiply step. The product register holds the partial sum
  // in its upper half and the not-yet-consumed multiplier bits in its lower
  // half; on the accepting edge the multiplier comes straight from DataIn so
  // the first step is not wasted.
  always_comb begin
    mul_src  = (state == ST_IDLE) ? {{W{1'b0}}, DataIn} : prod;
    mul_sum  = {1'b0, mul_src[2*W-1:W]} + (mul_src[0] ? {1'b0, Accu} : {(W+1){1'b0}});
    mul_next = {mul_sum, mul_src[W-1:1]};
  end

  // Control FSM, counter, accumulator and output registers. The accepting
  // edge always performs the first step of a multi-cycle operation, so an
  // operation of k steps finishes k edges after Start is sampled. cnt holds
  // the number of steps still to go after the current edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      run_mul <= 1'b0;
      prod    <= '0;
      Out     <= '0;
      Accu    <= '0;
      Carry   <= 1'b0;
      Zero    <= BR_NONE;
      Done    <= 1'b0;
      Halted  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start && !Halted) begin
            if (is_mul) begin
              prod    <= mul_next;
              cnt     <= SHW'(W - 1);
              run_mul <= 1'b1;
              state   <= ST_RUN;
            end else if (is_sliz && (sliz_k != '0)) begin
              Accu <= accu_shl;
              if (sliz_k == SHW'(1)) begin
                Out   <= accu_shl;
                Carry <= 1'b0;
                Zero  <= BR_NONE;
                Done  <= 1'b1;
              end else begin
                cnt     <= sliz_k - 1'b1;
                run_mul <= 1'b0;
                state   <= ST_RUN;
              end
            end else begin
              Out   <= c_result;
              Carry <= c_carry;
              Zero  <= c_zero;
              Done  <= 1'b1;
              if (c_load) begin
                Accu <= c_result;
              end
              if (c_halt) begin
                Halted <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt - 1'b1;
          if (run_mul) begin
            // Accu stays as the multiplicand until the product is complete.
            prod <= mul_next;
            if (cnt == SHW'(1)) begin
              Out   <= mul_next[W-1:0];
              Accu  <= mul_next[W-1:0];
              Carry <= |mul_next[2*W-1:W];
              Zero  <= BR_NONE;
              Done  <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            Accu <= accu_shl;
            if (cnt == SHW'(1)) begin
              Out   <= accu_shl;
              Carry <= 1'b0;
              Zero  <= BR_NONE;
              Done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W, 8, datapath and accumulator width in bits (W >= 4, power of 2).
REQ-002 Parameter SHW, $clog2(W)+1, width of the internal shift/multiply counter.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request to execute one operation; sampled only when Busy=0.
REQ-006 Op  input  1  opcode class (0 = register ops, 1 = immediate ops).
REQ-007 Func  input  4  operation select within class.
REQ-008 DataIn  input  W  operand B / immediate.
REQ-009 Out  output  W  registered result of last completed operation.
REQ-010 Accu  output  W  internal accumulator (operand A).
REQ-011 Carry  output  1  registered carry/borrow/overflow flag.
REQ-012 Zero  output  2  registered branch flag: 00 not taken, 01 forward, 10 backward.
REQ-013 Busy  output  1  multi-cycle operation in progress.
REQ-014 Done  output  1  one-cycle pulse, asserted in the cycle Out/flags become valid.
REQ-015 Halted  output  1  sticky halt indicator.

Function
REQ-016 Op=0 codes SHALL be: 0000 ADD, 0001 MOV, 0010 HALT, 0011 SLT, 0100 SET, 0101 SUB, 0110 SLL, 1000 OR, 1001 SLR, 1010 BEZR, 1101 MUL; Op=1 codes: 0000 SETI, 0001 SLIZ, 0010 SLTI; all others = NOP.
REQ-017 Single-cycle ops (all except SLIZ, MUL) with Start at edge n SHALL produce Out, flags and Done=1 after edge n+1; Busy stays 0.
REQ-018 ADD: {Carry,Out} = Accu + DataIn (W+1 bits); SUB: Out = Accu - DataIn mod 2^W, Carry = 1 iff DataIn > Accu (borrow).
REQ-019 SLT/SLTI: Out = 1 if DataIn >= Accu else 0 (unsigned); MOV: Out = Accu; SET/SETI: Out = DataIn; OR: Accu | DataIn; SLR: DataIn >> 1.
REQ-020 SLL: Out = (DataIn << 1) | Accu, Carry = DataIn[W-1].
REQ-021 BEZR: if Accu == 0 and DataIn[W-1] = 1, Out = -DataIn, Zero = 10; if Accu == 0 and DataIn[W-1] = 0, Out = DataIn, Zero = 01; else Out = 0, Zero = 00; Accu unchanged.
REQ-022 Accu SHALL load Out on Done for ADD, SUB, OR, SLL, SLR, SET, SETI, SLIZ, MUL; unchanged for MOV, SLT, SLTI, BEZR, HALT, NOP.
REQ-023 Carry SHALL be cleared by every op not defining it; Zero cleared by every op except BEZR.
REQ-024 FSM states IDLE, RUN: IDLE->RUN on accepted SLIZ with count k >= 1 or MUL; RUN->IDLE when counter reaches 0; Busy = (state == RUN).
REQ-025 SLIZ: k = min(DataIn, W); Accu shifted left one bit per cycle; k=0 completes as single-cycle op; else Done after edge n+k; result 0 when k = W.
REQ-026 MUL: shift-add, one multiplier bit per cycle, Done after edge n+W; Out = low W bits of Accu*DataIn; Carry = 1 iff high W bits nonzero.
REQ-027 Start while Busy=1 SHALL be ignored with no state change; Start in the Done cycle SHALL be accepted (back-to-back).
REQ-028 HALT SHALL set Halted=1 and Out=0; while Halted=1 all Start requests are ignored.
REQ-029 NOP SHALL produce Out=0, Done pulse, Accu unchanged.

Reset
REQ-030 Reset SHALL force Out, Accu, Carry, Zero, Busy, Done, Halted to 0 and FSM to IDLE, including mid-operation (partial result discarded, no Done).
REQ-031 Reset SHALL take priority over a simultaneous Start.

Structure
REQ-032 Package alu_pkg SHALL hold Op/Func code constants, FSM state enum and default W.
REQ-033 Single-cycle datapath SHALL be one combinational sub-module alu_comb; seq_alu holds FSM, counter, Accu and output registers.

Verification
REQ-034 W=8, Accu=0xF0, ADD DataIn=0x20 -> Out=0x10, Carry=1, Accu=0x10, Done one cycle later.
REQ-035 Accu=0, BEZR DataIn=0xFD -> Out=0x03, Zero=10; Accu=0, DataIn=0x05 -> Out=0x05, Zero=01; Accu=1 -> Zero=00.
REQ-036 Accu=0x03, SLIZ DataIn=3 -> Busy for 2 cycles, Done after 3 edges, Out=0x18; DataIn=9 -> Out=0x00 after 8 edges.
REQ-037 Accu=0x10, MUL DataIn=0x11 -> Done after 8 edges, Out=0x10, Carry=1; Start pulses while Busy ignored.
REQ-038 Reset asserted 3 cycles into MUL -> all outputs 0 next edge, no Done; HALT -> Halted=1, subsequent ADD ignored until Reset.
